// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/func encodings, PC source select,
// sequencer states and instruction classes.
package mips_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_src_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } seq_state_t;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_BRANCH,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_LOAD,
    CL_STORE,
    CL_SYSCALL,
    CL_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational opcode/func classifier, shared between the sequencer
// and the CU-side checks.
module mips_instr_class
  import mips_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_t iclass
);

  always_comb begin
    iclass = CL_ILLEGAL;
    case (opcode)
      OP_R_TYPE: begin
        if (func == FN_JR)           iclass = CL_JR;
        else if (func == FN_SYSCALL) iclass = CL_SYSCALL;
        else                         iclass = CL_ALU;
      end
      OP_J:                                     iclass = CL_J;
      OP_JAL:                                   iclass = CL_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:         iclass = CL_BRANCH;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_XORI:                                  iclass = CL_ALU;
      OP_LB, OP_LW:                             iclass = CL_LOAD;
      OP_SB, OP_SW:                             iclass = CL_STORE;
      default:                                  iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, memory
// handshakes with timeout, sticky halt status and retired-instruction count.
module mips_seq_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_write,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_t        state, state_nx;
  instr_class_t      iclass;
  pc_src_t           pc_sel;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, retire, set_bus_err, set_illegal;

  mips_instr_class u_class (
    .opcode (opcode),
    .func   (func),
    .iclass (iclass)
  );

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = PC_PLUS4;
    rf_write    = 1'b0;
    mem_wait    = 1'b0;
    retire      = 1'b0;
    set_bus_err = 1'b0;
    set_illegal = 1'b0;
    case (state)
      ST_BOOT: state_nx = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = ST_DECODE;
        end else begin
          mem_wait = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            set_bus_err = 1'b1;
            state_nx    = ST_HALT;
          end
        end
      end
      ST_DECODE: begin
        case (iclass)
          CL_J: begin
            pc_write = 1'b1;
            pc_sel   = PC_JUMP;
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end
          CL_JAL: state_nx = ST_WB;
          CL_SYSCALL: begin
            retire   = 1'b1;
            state_nx = ST_HALT;
          end
          CL_ILLEGAL: begin
            set_illegal = 1'b1;
            state_nx    = ST_HALT;
          end
          default: state_nx = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (iclass)
          CL_BRANCH: begin
            if (branch_cond) begin
              pc_write = 1'b1;
              pc_sel   = PC_BRANCH;
            end
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end
          CL_JR: begin
            pc_write = 1'b1;
            pc_sel   = PC_REG;
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_nx = ST_MEM;
          default:           state_nx = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iclass == CL_STORE);
        if (dmem_ready) begin
          if (iclass == CL_STORE) begin
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_WB;
          end
        end else begin
          mem_wait = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            set_bus_err = 1'b1;
            state_nx    = ST_HALT;
          end
        end
      end
      ST_WB: begin
        rf_write = 1'b1;
        // JAL's link write and jump share this cycle
        if (iclass == CL_JAL) begin
          pc_write = 1'b1;
          pc_sel   = PC_JUMP;
        end
        retire   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_BOOT;
    endcase
  end

  assign pc_src = pc_sel;
  assign halted = (state == ST_HALT);

  // Wait counter is zero whenever no request is stalled, so it is already
  // clear on entry to FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      wait_cnt  <= '0;
      retired   <= '0;
      bus_error <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= mem_wait ? wait_cnt + WAIT_W'(1) : '0;
      if (retire)      retired   <= retired + CNT_W'(1);
      if (set_bus_err) bus_error <= 1'b1;
      if (set_illegal) illegal   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Self-checking bench for mips_seq_ctrl: per-instruction expected cycle
// traces built from the instruction-class timing rules, random stimulus.
module tb_mips_seq_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    opcode = '0, func = '0;
  logic          branch_cond = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_write, pc_write, rf_write;
  logic [1:0]    pc_src;
  logic          halted, bus_error, illegal;
  logic [CW-1:0] retired;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;

  // Class codes: 0 ALU, 1 branch, 2 J, 3 JAL, 4 JR, 5 load, 6 store, 7 syscall, 8 illegal
  typedef struct packed {
    bit       ir, dr, bc;
    bit       ireq, dreq, we, irw, pcw;
    bit [1:0] src;
    bit       rfw;
  } cyc_t;

  mips_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
    .branch_cond(branch_cond), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .rf_write(rf_write), .halted(halted), .bus_error(bus_error),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_class(input bit [5:0] op, input bit [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h08) ? 4 : (fn == 6'h0C) ? 7 : 0;
      6'h02: return 2;
      6'h03: return 3;
      6'h04, 6'h05, 6'h06, 6'h07: return 1;
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: return 0;
      6'h20, 6'h23: return 5;
      6'h28, 6'h2B: return 6;
      default: return 8;
    endcase
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c    = '0;
    c.ir = 1'($urandom_range(1));
    c.dr = 1'($urandom_range(1));
    c.bc = 1'($urandom_range(1));
    return c;
  endfunction

  function automatic bit [7:0] strobes();
    return {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, rf_write};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_cond = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from its first FETCH cycle; iw/dw are stall cycles
  // before ready (>= TO means ready never comes).
  task automatic exec_instr(input bit [5:0] op, input bit [5:0] fn,
                            input int iw, input int dw, input bit bc);
    cyc_t     q[$];
    cyc_t     c;
    int       cls, outcome;
    bit [7:0] want;
    cls = ref_class(op, fn);
    outcome = 0;
    for (int k = 0; k < iw && k < TO; k++) begin
      c = blank(); c.ir = 1'b0; c.ireq = 1'b1; q.push_back(c);
    end
    if (iw >= TO) outcome = 3;
    else begin
      c = blank(); c.ir = 1'b1; c.ireq = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
      q.push_back(c);
      c = blank();
      if (cls == 2) begin c.pcw = 1'b1; c.src = 2'd2; end
      q.push_back(c);
      if (cls == 8) outcome = 1;
      else if (cls == 7) outcome = 2;
      else if (cls == 3) begin
        c = blank(); c.rfw = 1'b1; c.pcw = 1'b1; c.src = 2'd2; q.push_back(c);
      end else if (cls != 2) begin
        c = blank();
        if (cls == 1) begin c.bc = bc; c.pcw = bc; c.src = bc ? 2'd1 : 2'd0; end
        if (cls == 4) begin c.pcw = 1'b1; c.src = 2'd3; end
        q.push_back(c);
        if (cls == 0) begin c = blank(); c.rfw = 1'b1; q.push_back(c); end
        if (cls == 5 || cls == 6) begin
          for (int k = 0; k < dw && k < TO; k++) begin
            c = blank(); c.dr = 1'b0; c.dreq = 1'b1; c.we = (cls == 6); q.push_back(c);
          end
          if (dw >= TO) outcome = 3;
          else begin
            c = blank(); c.dr = 1'b1; c.dreq = 1'b1; c.we = (cls == 6); q.push_back(c);
            if (cls == 5) begin c = blank(); c.rfw = 1'b1; q.push_back(c); end
          end
        end
      end
    end
    foreach (q[i]) begin
      @(negedge clk);
      opcode = op; func = fn;
      imem_ready = q[i].ir; dmem_ready = q[i].dr; branch_cond = q[i].bc;
      #1;
      want = {q[i].ireq, q[i].dreq, q[i].we, q[i].irw, q[i].pcw, q[i].src, q[i].rfw};
      tests++;
      if (strobes() !== want) begin
        fails++;
        $display("FAIL strobes op=%h fn=%h step %0d: got %b want %b", op, fn, i, strobes(), want);
      end
    end
    @(posedge clk);
    #1;
    if (outcome == 0 || outcome == 2) exp_ret++;
    tests++;
    if (retired !== CW'(exp_ret)) begin
      fails++;
      $display("FAIL retired op=%h: got %0d want %0d", op, retired, CW'(exp_ret));
    end
    tests++;
    if ({halted, bus_error, illegal} !== {outcome != 0, outcome == 3, outcome == 1}) begin
      fails++;
      $display("FAIL status op=%h: got halt/bus/ill %b want %b", op,
               {halted, bus_error, illegal}, {outcome != 0, outcome == 3, outcome == 1});
    end
    if (outcome != 0) begin
      repeat (3) begin
        @(negedge clk);
        c = blank();
        imem_ready = c.ir; dmem_ready = c.dr; branch_cond = c.bc;
        #1;
        tests++;
        if ({strobes(), halted} !== 9'b0_0000_0001) begin
          fails++;
          $display("FAIL halt_quiet op=%h: got %b want 000000001", op, {strobes(), halted});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    tests++;
    if ({strobes(), halted, bus_error, illegal, retired} !== '0) begin
      fails++;
      $display("FAIL reset_values: got %b want all zero",
               {strobes(), halted, bus_error, illegal, retired});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
    #1;
    tests++;
    if ({strobes(), halted} !== '0) begin
      fails++;
      $display("FAIL boot_quiet: got %b want all zero", {strobes(), halted});
    end
  endtask

  task automatic test_alu();
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h0D, 6'h15, 2, 0, 1'b1);
    exec_instr(6'h00, 6'h20, 1, 0, 1'b0);
  endtask

  task automatic test_load_store();
    exec_instr(6'h23, 6'h00, 0, 3, 1'b0);
    exec_instr(6'h20, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h2B, 6'h00, 1, 1, 1'b0);
    exec_instr(6'h28, 6'h00, 0, 0, 1'b0);
  endtask

  task automatic test_branch();
    exec_instr(6'h04, 6'h00, 0, 0, 1'b1);
    exec_instr(6'h04, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h05, 6'h00, 1, 0, 1'b1);
    exec_instr(6'h06, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h07, 6'h00, 0, 0, 1'b1);
  endtask

  task automatic test_jumps();
    exec_instr(6'h02, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h03, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h00, 6'h08, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    exec_instr(6'h08, 6'h00, TO - 1, 0, 1'b0);
    exec_instr(6'h23, 6'h00, 0, TO - 1, 1'b0);
    exec_instr(6'h08, 6'h00, TO, 0, 1'b0);
    do_reset();
    exec_instr(6'h23, 6'h00, 0, TO, 1'b0);
    do_reset();
    exec_instr(6'h2B, 6'h00, 0, TO, 1'b0);
  endtask

  task automatic test_halt_ops();
    do_reset();
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h3F, 6'h00, 0, 0, 1'b0);
    do_reset();
    exec_instr(6'h02, 6'h00, 0, 0, 1'b0);
    exec_instr(6'h00, 6'h0C, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0);
    @(negedge clk); opcode = 6'h23; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_req: got %b want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    exp_ret = 0;
    #1;
    tests++;
    if ({strobes(), halted, retired} !== '0) begin
      fails++;
      $display("FAIL mid_reset_drop: got %b want all zero", {strobes(), halted, retired});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (strobes() !== 8'h00) begin
      fails++;
      $display("FAIL mid_boot: got %b want 00000000", strobes());
    end
    @(negedge clk); #1;
    tests++;
    if (strobes() !== 8'b1000_0000) begin
      fails++;
      $display("FAIL mid_fetch: got %b want 10000000", strobes());
    end
  endtask

  task automatic test_random();
    bit [5:0] ops [17];
    bit [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
            6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h20, 6'h23, 6'h28, 6'h2B};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(16)];
      fn = 6'($urandom);
      if (op == 6'h00 && fn == 6'h0C) fn = 6'h20;
      exec_instr(op, fn, $urandom_range(TO - 1), $urandom_range(TO - 1),
                 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jumps();
    test_timeout();
    test_halt_ops();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
